// File: rtl/lock_pkg.sv
// Shared definitions for the button front-end and the electronics_lock it
// feeds: arbiter state encoding, default timing parameters and the symbol
// encoding the lock expects on its b0/b1 inputs.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    BLOCKED = 2'd2
  } arb_state_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  localparam logic SYM0 = 1'b0;
  localparam logic SYM1 = 1'b1;

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: synchroniser chain, symmetric debounce counter
// and a registered one-cycle rising-edge flag on the debounced level.
//   clk    system clock
//   reset  synchronous active-low reset
//   raw    raw asynchronous button level
//   deb    debounced level
//   rise   one-cycle flag, debounced level went 0->1 on the previous edge
module debounce_channel
  import lock_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync;
  logic [CNT_W-1:0]       cnt;
  logic                   deb_d;

  assign sync = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_ff <= '0;
      cnt     <= '0;
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
      // The flip happens on the edge where the count would reach
      // DEBOUNCE_CYCLES, so cnt never holds that value and cannot wrap.
      if (sync != deb) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb <= sync;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
      deb_d <= deb;
      rise  <= deb & ~deb_d;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Front-end for electronics_lock: debounces two raw buttons and arbitrates
// so that only one press at a time produces a symbol pulse.
//   clk       system clock
//   reset     synchronous active-low reset
//   btn0_raw  raw button 0 (async, active-high, bouncy)
//   btn1_raw  raw button 1 (async, active-high, bouncy)
//   b0        one-cycle pulse, symbol 0 accepted
//   b1        one-cycle pulse, symbol 1 accepted
//   held      arbiter not idle (a button is down or the pair is blocked)
//
// state   | meaning
// IDLE    | no button down, next clean rise is accepted
// HELD    | a symbol was accepted, waiting for both buttons released
// BLOCKED | both rose together, nothing accepted until both released
module button_conditioner
  import lock_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn0_raw,
  input  logic btn1_raw,
  output logic b0,
  output logic b1,
  output logic held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic deb0, deb1;
  logic rise0, rise1;

  arb_state_t state, state_next;
  logic       b0_next, b1_next;
  logic       sym;

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch0 (
    .clk  (clk),
    .reset(reset),
    .raw  (btn0_raw),
    .deb  (deb0),
    .rise (rise0)
  );

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch1 (
    .clk  (clk),
    .reset(reset),
    .raw  (btn1_raw),
    .deb  (deb1),
    .rise (rise1)
  );

  always_comb begin
    state_next = state;
    b0_next    = 1'b0;
    b1_next    = 1'b0;
    sym        = rise1 ? SYM1 : SYM0;
    case (state)
      IDLE: begin
        if (rise0 && rise1) begin
          state_next = BLOCKED;
        end else if (rise0 || rise1) begin
          b0_next    = (sym == SYM0);
          b1_next    = (sym == SYM1);
          state_next = HELD;
        end
      end
      HELD, BLOCKED: begin
        // Rises seen here are deliberately dropped; only a full release
        // re-arms the arbiter.
        if (!deb0 && !deb1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      b0    <= 1'b0;
      b1    <= 1'b0;
      held  <= 1'b0;
    end else begin
      state <= state_next;
      b0    <= b0_next;
      b1    <= b1_next;
      held  <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner. A reference model derives the
// expected pulses and held level from the raw input history using the
// debounce window rule; a monitor compares them against the DUT.
module tb_button_conditioner;

  localparam int S    = 2;
  localparam int D    = 4;
  localparam int MAXC = 8000;

  logic clk      = 1'b0;
  logic reset    = 1'b0;
  logic btn0_raw = 1'b0;
  logic btn1_raw = 1'b0;
  logic b0, b1, held;

  button_conditioner #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn0_raw(btn0_raw),
    .btn1_raw(btn1_raw),
    .b0      (b0),
    .b1      (b1),
    .held    (held)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit sym;
    int cyc;
  } exp_t;

  exp_t sb_q[$];

  bit raw_h [2][MAXC];
  bit deb_h [2][MAXC];
  bit rst_h [MAXC];
  bit held_h[MAXC];

  int cyc      = -1;
  int checks   = 0;
  int failures = 0;

  // Synchronised level visible after edge e: the raw sample taken S-1 edges
  // earlier, unless a reset edge intervened.
  function automatic bit synced(int ch, int e);
    if (e - S + 1 < 0) return 1'b0;
    for (int i = e - S + 1; i <= e; i++)
      if (rst_h[i]) return 1'b0;
    return raw_h[ch][e - S + 1];
  endfunction

  // Debounced level after edge m: flips only if the synchronised level seen
  // at each of the last D edges differed from it, with no reset in between.
  function automatic bit deb_at(int ch, int m);
    bit prev;
    bit flip;
    if (rst_h[m]) return 1'b0;
    prev = (m > 0) ? deb_h[ch][m-1] : 1'b0;
    if (m - D + 1 < 0) return prev;
    flip = 1'b1;
    for (int j = 0; j < D; j++) begin
      if (rst_h[m-j]) flip = 1'b0;
      if (synced(ch, m - j - 1) == prev) flip = 1'b0;
    end
    return flip ? ~prev : prev;
  endfunction

  // A debounced 0->1 step at edge m-2 is acted on by the arbiter at edge m.
  function automatic bit rise_at(int ch, int m);
    bit d2, d3;
    if (m < 2) return 1'b0;
    if (rst_h[m-1]) return 1'b0;
    d2 = deb_h[ch][m-2];
    d3 = (m >= 3) ? deb_h[ch][m-3] : 1'b0;
    return d2 && !d3;
  endfunction

  // Reference model
  initial begin : model
    int  m;
    bit  busy;
    bit  r0, r1;
    busy = 1'b0;
    forever begin
      @(posedge clk);
      m = cyc + 1;
      if (m < MAXC) begin
        rst_h[m]    = !reset;
        raw_h[0][m] = btn0_raw;
        raw_h[1][m] = btn1_raw;
        deb_h[0][m] = deb_at(0, m);
        deb_h[1][m] = deb_at(1, m);
        if (rst_h[m]) begin
          busy = 1'b0;
        end else if (!busy) begin
          r0 = rise_at(0, m);
          r1 = rise_at(1, m);
          if (r0 && r1) begin
            busy = 1'b1;
          end else if (r0 || r1) begin
            sb_q.push_back('{sym: r1, cyc: m});
            busy = 1'b1;
          end
        end else if (m >= 1 && !deb_h[0][m-1] && !deb_h[1][m-1]) begin
          busy = 1'b0;
        end
        held_h[m] = busy;
      end
      cyc = m;
    end
  end

  // Monitor
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (cyc >= 0 && cyc < MAXC) begin
        checks++;
        if (held !== held_h[cyc]) begin
          failures++;
          $display("FAIL held cyc=%0d got=%b exp=%b", cyc, held, held_h[cyc]);
        end
        checks++;
        if (b0 === 1'b1 && b1 === 1'b1) begin
          failures++;
          $display("FAIL exclusive cyc=%0d got b0=%b b1=%b exp not both", cyc, b0, b1);
        end
        if (b0 === 1'b1 || b1 === 1'b1) begin
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse cyc=%0d got b0=%b b1=%b exp none", cyc, b0, b1);
          end else begin
            e = sb_q.pop_front();
            if (e.sym != b1 || e.cyc != cyc) begin
              failures++;
              $display("FAIL pulse cyc=%0d got sym=%b exp sym=%b at cyc=%0d",
                       cyc, b1, e.sym, e.cyc);
            end
          end
        end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
          checks++;
          failures++;
          e = sb_q.pop_front();
          $display("FAIL missing_pulse cyc=%0d got none exp sym=%b at cyc=%0d",
                   cyc, e.sym, e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic a, input logic b, input int n);
    btn0_raw = a;
    btn1_raw = b;
    repeat (n) @(negedge clk);
  endtask

  initial begin : stimulus
    @(negedge clk);
    // reset with toggling inputs
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive(i[0], ~i[0], 1);
    reset = 1'b1;
    drive(0, 0, 12);
    // clean press
    drive(1, 0, 20);
    drive(0, 0, 15);
    // glitches then a real press
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 3);
      drive(0, 0, 3);
    end
    drive(0, 1, 10);
    drive(0, 0, 15);
    // simultaneous press
    drive(1, 1, 15);
    drive(0, 0, 15);
    drive(0, 1, 10);
    drive(0, 0, 15);
    // overlap
    drive(1, 0, 10);
    drive(1, 1, 10);
    drive(0, 0, 15);
    drive(0, 1, 10);
    drive(0, 0, 15);
    // reset mid-debounce, then a symbol sequence
    drive(1, 0, 2);
    reset = 1'b0;
    drive(0, 0, 2);
    reset = 1'b1;
    drive(0, 0, 10);
    drive(1, 0, 8); drive(0, 0, 5);
    drive(0, 1, 8); drive(0, 0, 5);
    drive(1, 0, 8); drive(0, 0, 5);
    drive(0, 1, 8); drive(0, 0, 5);
    drive(0, 1, 8); drive(0, 0, 15);
    // randomized bouncing, presses and occasional resets
    for (int i = 0; i < 350 && cyc < MAXC - 200; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        drive(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
              $urandom_range(1, 3));
        reset = 1'b1;
      end
      drive(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
            $urandom_range(1, 10));
    end
    drive(0, 0, 40);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL leftover got=%0d pending exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #(MAXC * 10);
    $display("FAIL watchdog cyc=%0d got timeout exp finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
